// File: rtl/tv_pkg.sv
// Shared constants, FSM encoding and counter helper for the raster coordinate generator.
package tv_pkg;
  localparam int COORD_W  = 10;
  localparam int H_START  = 16;
  localparam int H_ACTIVE = 720;
  localparam int V_START  = 22;
  localparam int V_ACTIVE = 288;
  localparam int V_MAX    = 320;

  localparam logic [COORD_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Counters stick at all-ones rather than wrapping back into the active window.
  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == CNT_MAX) ? v : v + COORD_W'(1);
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// Rising-edge detector: one history register, combinational edge output (no added latency).
module sync_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_i,
  output logic rise_o
);
  logic sig_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sig_q <= 1'b0;
    else          sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
endmodule

// File: rtl/tv_coord_gen.sv
// Raster coordinate generator: counts pixels/lines from decoder syncs and emits
// registered active-window coordinates, an end-of-frame pulse and a missing-vsync flag.
module tv_coord_gen #(
  parameter int H_START  = tv_pkg::H_START,
  parameter int H_ACTIVE = tv_pkg::H_ACTIVE,
  parameter int V_START  = tv_pkg::V_START,
  parameter int V_ACTIVE = tv_pkg::V_ACTIVE,
  parameter int V_MAX    = tv_pkg::V_MAX
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       pix_valid,
  input  logic                       hs,
  input  logic                       vs,
  output logic [tv_pkg::COORD_W-1:0] tv_x,
  output logic [tv_pkg::COORD_W-1:0] tv_y,
  output logic                       en,
  output logic                       frame_done,
  output logic                       err
);
  import tv_pkg::*;

  localparam logic [COORD_W-1:0] H_LO   = COORD_W'(H_START);
  localparam logic [COORD_W-1:0] H_HI   = COORD_W'(H_START + H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LO   = COORD_W'(V_START);
  localparam logic [COORD_W-1:0] V_HI   = COORD_W'(V_START + V_ACTIVE);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_START + V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] V_END  = COORD_W'(V_MAX);

  logic hs_rise, vs_rise;

  sync_edge_det u_hs_edge (.clk(clk), .reset_n(reset_n), .sig_i(hs), .rise_o(hs_rise));
  sync_edge_det u_vs_edge (.clk(clk), .reset_n(reset_n), .sig_i(vs), .rise_o(vs_rise));

  state_e             state_q, state_d;
  logic [COORD_W-1:0] pix_q, pix_d, line_q, line_d;
  logic [COORD_W-1:0] pix_base, line_base;
  logic [COORD_W-1:0] tv_x_q, tv_y_q;
  logic               en_q, fd_q, err_q;
  logic               run_now, active, fd_set, overflow;

  // pix_base/line_base are the position of a pixel arriving this cycle, so a pixel
  // coinciding with a sync edge lands at pixel 0 of the new line.
  always_comb begin
    pix_base  = pix_q;
    line_base = line_q;
    if (vs_rise) begin
      pix_base  = '0;
      line_base = '0;
    end else if (hs_rise) begin
      pix_base  = '0;
      line_base = sat_inc(line_q);
    end

    run_now  = (state_q == RUN) || vs_rise;
    active   = run_now && pix_valid &&
               (pix_base >= H_LO) && (pix_base < H_HI) &&
               (line_base >= V_LO) && (line_base < V_HI);
    fd_set   = (state_q == RUN) && hs_rise && !vs_rise && (line_q == V_LAST);
    overflow = (state_q == RUN) && !vs_rise && (line_base >= V_END);

    pix_d   = pix_q;
    line_d  = line_q;
    if (run_now) begin
      pix_d  = pix_valid ? sat_inc(pix_base) : pix_base;
      line_d = line_base;
    end

    state_d = state_q;
    if (vs_rise)       state_d = RUN;
    else if (overflow) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pix_q   <= '0;
      line_q  <= '0;
      tv_x_q  <= '0;
      tv_y_q  <= '0;
      en_q    <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      en_q    <= active;
      fd_q    <= fd_set;
      err_q   <= err_q | overflow;
      if (active) begin
        tv_x_q <= pix_base - H_LO;
        tv_y_q <= line_base - V_LO;
      end
    end
  end

  assign tv_x       = tv_x_q;
  assign tv_y       = tv_y_q;
  assign en         = en_q;
  assign frame_done = fd_q;
  assign err        = err_q;
endmodule

// File: tb/tb_tv_coord_gen.sv
// Directed bench for tv_coord_gen: small-geometry instance plus a wide-line instance.
module tb_tv_coord_gen;
  logic       clk, reset_n, pix_valid, hs, vs;
  logic [9:0] tv_x, tv_y, tv_x2, tv_y2;
  logic       en, frame_done, err, en2, frame_done2, err2;
  int         checks, errors, en_seen, fd_seen;

  tv_coord_gen #(.H_START(2), .H_ACTIVE(4), .V_START(1), .V_ACTIVE(2), .V_MAX(6)) dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .hs(hs), .vs(vs),
    .tv_x(tv_x), .tv_y(tv_y), .en(en), .frame_done(frame_done), .err(err));

  tv_coord_gen #(.H_START(16), .H_ACTIVE(720), .V_START(1), .V_ACTIVE(2), .V_MAX(6)) dut2 (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .hs(hs), .vs(vs),
    .tv_x(tv_x2), .tv_y(tv_y2), .en(en2), .frame_done(frame_done2), .err(err2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input logic pv, input logic h, input logic v);
    pix_valid = pv; hs = h; vs = v;
    @(posedge clk); #1;
    if (en) en_seen++;
    if (frame_done) fd_seen++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pix_valid = 1'b0; hs = 1'b0; vs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", en); end
    checks++; if (tv_x !== 10'd0) begin errors++; $display("FAIL reset_tv_x got %0d exp 0", tv_x); end
    checks++; if (tv_y !== 10'd0) begin errors++; $display("FAIL reset_tv_y got %0d exp 0", tv_y); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", frame_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    reset_n = 1'b1;
    en_seen = 0; fd_seen = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      repeat (5) cyc(1'b1, 1'b0, 1'b0);
    end
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    checks++; if (en_seen != 0) begin errors++; $display("FAIL novs_en_count got %0d exp 0", en_seen); end
    checks++; if (fd_seen != 0) begin errors++; $display("FAIL novs_fd_count got %0d exp 0", fd_seen); end
    checks++; if (tv_x !== 10'd0 || tv_y !== 10'd0) begin
      errors++; $display("FAIL novs_coords got %0d,%0d exp 0,0", tv_x, tv_y);
    end
  endtask

  task automatic test_frame();
    logic exp_en;
    en_seen = 0; fd_seen = 0;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 4; l++) begin
      if (l > 0) begin
        cyc(1'b0, 1'b1, 1'b0);
        checks++;
        if (frame_done !== (l == 3)) begin
          errors++; $display("FAIL frame_fd line %0d got %b exp %b", l, frame_done, (l == 3));
        end
      end
      for (int p = 0; p < 8; p++) begin
        cyc(1'b1, 1'b0, 1'b0);
        exp_en = (l == 1 || l == 2) && p >= 2 && p < 6;
        checks++;
        if (en !== exp_en) begin
          errors++; $display("FAIL frame_en l%0d p%0d got %b exp %b", l, p, en, exp_en);
        end
        if (exp_en) begin
          checks++;
          if (tv_x !== 10'(p - 2) || tv_y !== 10'(l - 1)) begin
            errors++; $display("FAIL frame_xy l%0d p%0d got %0d,%0d exp %0d,%0d", l, p, tv_x, tv_y, p - 2, l - 1);
          end
        end
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (en_seen != 8) begin errors++; $display("FAIL frame_en_count got %0d exp 8", en_seen); end
    checks++; if (fd_seen != 1) begin errors++; $display("FAIL frame_fd_count got %0d exp 1", fd_seen); end
  endtask

  task automatic test_coincident();
    cyc(1'b1, 1'b1, 1'b1);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL coinc_en got %b exp 0", en); end
    cyc(1'b0, 1'b0, 1'b0);
    for (int p = 1; p < 4; p++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++; if (en !== 1'b0) begin errors++; $display("FAIL coinc_line0 p%0d got %b exp 0", p, en); end
    end
    cyc(1'b0, 1'b1, 1'b0);
    for (int p = 0; p < 4; p++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++;
      if (en !== (p >= 2)) begin errors++; $display("FAIL coinc_line1 p%0d got %b exp %b", p, en, (p >= 2)); end
    end
    checks++; if (tv_x !== 10'd1 || tv_y !== 10'd0) begin
      errors++; $display("FAIL coinc_xy got %0d,%0d exp 1,0", tv_x, tv_y);
    end
  endtask

  task automatic test_saturate();
    int n, last, first;
    n = 0; last = -1; first = -1;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 1100; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (en2) begin
        if (first < 0) first = int'(tv_x2);
        n++; last = int'(tv_x2);
      end
    end
    checks++; if (n != 720) begin errors++; $display("FAIL sat_en_count got %0d exp 720", n); end
    checks++; if (first != 0) begin errors++; $display("FAIL sat_first_x got %0d exp 0", first); end
    checks++; if (last != 719) begin errors++; $display("FAIL sat_last_x got %0d exp 719", last); end
    checks++; if (tv_y2 !== 10'd0) begin errors++; $display("FAIL sat_tv_y got %0d exp 0", tv_y2); end
  endtask

  task automatic test_err();
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      checks++;
      if (err !== (k == 6)) begin errors++; $display("FAIL err_hs%0d got %b exp %b", k, err, (k == 6)); end
      cyc(1'b0, 1'b0, 1'b0);
    end
    checks++; if (dut.state_q !== tv_pkg::IDLE) begin errors++; $display("FAIL err_state got %0d exp IDLE", dut.state_q); end
    en_seen = 0;
    cyc(1'b0, 1'b1, 1'b0);
    repeat (8) cyc(1'b1, 1'b0, 1'b0);
    checks++; if (en_seen != 0) begin errors++; $display("FAIL err_idle_en got %0d exp 0", en_seen); end
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    checks++; if (en !== 1'b1 || tv_x !== 10'd0 || tv_y !== 10'd0) begin
      errors++; $display("FAIL err_resume got en=%b x=%0d y=%0d exp 1,0,0", en, tv_x, tv_y);
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
  endtask

  task automatic test_async_reset();
    cyc(1'b0, 1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    checks++; if (en !== 1'b1 || tv_x !== 10'd1 || tv_y !== 10'd1) begin
      errors++; $display("FAIL arst_pre got en=%b x=%0d y=%0d exp 1,1,1", en, tv_x, tv_y);
    end
    pix_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (en !== 1'b0 || tv_x !== 10'd0 || tv_y !== 10'd0) begin
      errors++; $display("FAIL arst_out got en=%b x=%0d y=%0d exp 0,0,0", en, tv_x, tv_y);
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL arst_err got %b exp 0", err); end
    checks++; if (dut.state_q !== tv_pkg::IDLE) begin errors++; $display("FAIL arst_state got %0d exp IDLE", dut.state_q); end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    en_seen = 0;
    cyc(1'b0, 1'b1, 1'b0);
    repeat (6) cyc(1'b1, 1'b0, 1'b0);
    checks++; if (en_seen != 0) begin errors++; $display("FAIL arst_novs_en got %0d exp 0", en_seen); end
  endtask

  initial begin
    checks = 0; errors = 0; en_seen = 0; fd_seen = 0;
    test_reset();
    test_frame();
    test_coincident();
    test_saturate();
    test_err();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tv_coord_gen.md
# tv_coord_gen

Raster coordinate generator that drives the pixel-coordinate side of the mask logic. It consumes the synchronous pixel strobe and line/field sync pulses from the video decoder and produces registered `tv_x`/`tv_y` coordinates plus a per-pixel `en` strobe. Mask generation and the fish-counting pipeline consume these outputs directly. It also flags the end of each active frame and detects a missing field sync.

## Interface
- `H_START`, 16: valid pixels skipped after each line start before active video.
- `H_ACTIVE`, 720: active pixels per line; `H_START+H_ACTIVE` ≤ 1023.
- `V_START`, 22: lines skipped after field start.
- `V_ACTIVE`, 288: active lines per field; `V_START+V_ACTIVE` < `V_MAX`.
- `V_MAX`, 320: line count at which a missing `vs` is declared.

- `clk`  in  1  pixel-domain clock
- `reset_n`  in  1  asynchronous, active-low reset
- `pix_valid`  in  1  one decoded pixel this cycle
- `hs`  in  1  line sync, active high; rising edge = line start
- `vs`  in  1  field sync, active high; rising edge = field start
- `tv_x`  out  10  active-window column of last accepted pixel
- `tv_y`  out  10  active-window row of last accepted pixel
- `en`  out  1  one-cycle strobe, `tv_x`/`tv_y` valid for an active pixel
- `frame_done`  out  1  one-cycle pulse after last active line ends
- `err`  out  1  sticky: `V_MAX` lines seen without `vs`

## Operation
- Inputs are synchronous to `clk`. Rising edges are detected as input=1 AND previous-cycle register=0. Detection is combinational and adds no latency.
- State machine has two states:
  - `IDLE`: entered on reset. Pixels and `hs` edges are ignored. A `vs` edge moves the FSM to `RUN`.
  - `RUN`: normal counting.
- Counters, both 10-bit, saturating at 1023 with no wrap:
  - `pix_cnt` counts valid pixels in the line.
  - `line_cnt` counts lines in the field.
- A `vs` edge sets `line_cnt`=0 and `pix_cnt`=0.
- An `hs` edge sets `pix_cnt`=0 and increments `line_cnt`.
- If `hs` and `vs` edges occur in the same cycle, `vs` wins: `line_cnt`=0.
- If `pix_valid` coincides with an `hs`/`vs` edge, that pixel is pixel 0 of the new line.
- A pixel is active when `H_START` ≤ `pix_cnt` < `H_START+H_ACTIVE` and `V_START` ≤ `line_cnt` < `V_START+V_ACTIVE`.
- For an active pixel: `tv_x` = `pix_cnt` − `H_START`, `tv_y` = `line_cnt` − `V_START`, and `en`=1 for one cycle.
- For a non-active pixel: `en`=0 and `tv_x`/`tv_y` hold their previous value.
- `frame_done` pulses on the `hs` edge that moves `line_cnt` from `V_START+V_ACTIVE−1` to `V_START+V_ACTIVE`. It pulses once per field.
- If `line_cnt` reaches `V_MAX` in `RUN`:
  - `err` is set.
  - The FSM goes to `IDLE`, and the next `vs` resumes `RUN`.
  - `err` is cleared only by reset.

## Timing
- Reset values: `tv_x`=0, `tv_y`=0, `en`=0, `frame_done`=0, `err`=0; state `IDLE`; counters 0; edge registers 0.
- Reset takes effect immediately on `reset_n` low, including mid-line and mid-frame. After release, no `en` is produced until a `vs` edge.
- Latency: `pix_valid` in cycle N gives `en`/`tv_x`/`tv_y` registered at cycle N+1.
- `frame_done` is registered and appears one cycle after the qualifying `hs` edge.
- Back-to-back `pix_valid` (every cycle) is supported: one `en` per cycle, `tv_x` incrementing by 1.
- No backpressure; the consumer must accept every `en`.

## Structure
- Package `tv_pkg`:
  - `COORD_W`=10.
  - Default geometry constants (`H_START`, `H_ACTIVE`, `V_START`, `V_ACTIVE`, `V_MAX`).
  - FSM state enum {`IDLE`, `RUN`}.
- Sub-module `sync_edge_det`: one register plus a rising-edge output. Instantiated once for `hs` and once for `vs`.

## Test plan
All scenarios use `H_START`=2, `H_ACTIVE`=4, `V_START`=1, `V_ACTIVE`=2, `V_MAX`=6 unless stated.
- Reset, then 20 `pix_valid` and 3 `hs` with no `vs` -> `en` never asserted; all outputs remain 0.
- Stimulus: `vs`, then 4 lines of 8 pixels each, `hs` between lines. Required response:
  - exactly 8 `en` strobes;
  - line 1 gives `tv_x`=0..3 at `tv_y`=0, line 2 gives `tv_x`=0..3 at `tv_y`=1;
  - `frame_done` pulses once, one cycle after the 3rd `hs`.
- `hs` and `vs` rising in the same cycle together with `pix_valid` -> pixel treated as line 0, pixel 0; `en`=0; the next `hs` gives `line_cnt`=1.
- One line of 1100 pixels at line 1, with `H_ACTIVE`=720 and `H_START`=16 -> exactly 720 `en` strobes, last `tv_x`=719; `pix_cnt` saturates at 1023 with no second active run.
- Stimulus: `vs`, then 6 `hs` with no `vs`. Required response:
  - `err`=1 and FSM in `IDLE`;
  - further pixels give `en`=0;
  - a new `vs` restores `en` while `err` stays 1.
- `reset_n` low mid-active-line -> `en`/`tv_x`/`tv_y` go to 0 without waiting for a `clk` edge; the FSM returns to `IDLE`.
